div_rem_32bit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU group. It computes quotient and remainder in one operation under a start/done handshake, using one restoring-division step per cycle. It sits beside the combinational ALU compare/arithmetic units in the execute stage. It shares their I_OP_A/I_OP_B/I_U operand convention: I_U=1 selects unsigned, I_U=0 selects signed.

---
 rtl/div_rem_32bit.sv | 133 +++++++++++++
 tb/tb_div_rem_32bit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_rem_32bit.sv
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; fixed 33-cycle latency from accept to O_DONE.
module div_rem_32bit (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_START,
  input  logic [31:0] I_OP_A,
  input  logic [31:0] I_OP_B,
  input  logic        I_U,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic [31:0] O_QUOT,
  output logic [31:0] O_REM,
  output logic [1:0]  O_DBG_STATE
);

  // Handshake: I_START is taken only in IDLE; operands are captured on that
  // same edge. O_DONE pulses for one cycle (in IDLE) and O_QUOT/O_REM hold
  // their value until the next O_DONE. O_BUSY and O_DONE are never both high.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_op_a;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_div0;
  logic        r_ovf;

  logic        w_accept;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_rem_sh;
  logic [32:0] w_trial;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (I_START) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC:  if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign O_BUSY      = (r_state != S_IDLE);
  assign O_DBG_STATE = r_state;

  assign w_a_neg = !I_U && I_OP_A[31];
  assign w_b_neg = !I_U && I_OP_B[31];
  assign w_a_mag = w_a_neg ? (~I_OP_A + 32'd1) : I_OP_A;
  assign w_b_mag = w_b_neg ? (~I_OP_B + 32'd1) : I_OP_B;

  // Partial remainder stays below the divisor, so 33 bits hold both the
  // shifted remainder and the trial difference; bit 32 is the borrow.
  assign w_rem_sh = {r_rem, r_dvd[31]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};

  always_comb begin
    w_quot_fix = r_qneg ? (~r_dvd + 32'd1) : r_dvd;
    w_rem_fix  = r_rneg ? (~r_rem + 32'd1) : r_rem;
    if (r_div0) begin
      w_quot_fix = 32'hFFFF_FFFF;
      w_rem_fix  = r_op_a;
    end else if (r_ovf) begin
      w_quot_fix = 32'h8000_0000;
      w_rem_fix  = 32'h0000_0000;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_cnt  <= 5'd0;
      r_rem  <= 32'd0;
      r_dvd  <= 32'd0;
      r_dvs  <= 32'd0;
      r_op_a <= 32'd0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_div0 <= 1'b0;
      r_ovf  <= 1'b0;
      O_DONE <= 1'b0;
      O_QUOT <= 32'd0;
      O_REM  <= 32'd0;
    end else begin
      O_DONE <= 1'b0;
      if (w_accept) begin
        r_dvd  <= w_a_mag;
        r_dvs  <= w_b_mag;
        r_op_a <= I_OP_A;
        r_rem  <= 32'd0;
        r_cnt  <= 5'd0;
        r_qneg <= w_a_neg ^ w_b_neg;
        r_rneg <= w_a_neg;
        r_div0 <= (I_OP_B == 32'd0);
        r_ovf  <= !I_U && (I_OP_A == 32'h8000_0000) && (I_OP_B == 32'hFFFF_FFFF);
      end else if (r_state == S_CALC) begin
        r_rem  <= w_trial[32] ? w_rem_sh[31:0] : w_trial[31:0];
        r_dvd  <= {r_dvd[30:0], ~w_trial[32]};
        r_cnt  <= r_cnt + 5'd1;
      end else if (r_state == S_FIX) begin
        O_QUOT <= w_quot_fix;
        O_REM  <= w_rem_fix;
        O_DONE <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_rem_32bit.sv
// Self-checking bench for div_rem_32bit: directed RV32M cases, handshake,
// reset abort and randomized operands against a plain-arithmetic model.
module tb_div_rem_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        u;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fails;
  logic [63:0] exp_q[$];

  div_rem_32bit dut (
    .I_CLK       (clk),
    .I_RST_N     (rst_n),
    .I_START     (start),
    .I_OP_A      (op_a),
    .I_OP_B      (op_b),
    .I_U         (u),
    .O_BUSY      (busy),
    .O_DONE      (done),
    .O_QUOT      (quot),
    .O_REM       (rem),
    .O_DBG_STATE (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic uns);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (uns) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 40);
      2: v = 32'd0 - $urandom_range(1, 40);
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'd0;
          1: v = 32'd1;
          2: v = 32'hFFFF_FFFF;
          default: v = 32'h8000_0000;
        endcase
      end
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic uns);
    op_a  = a;
    op_b  = b;
    u     = uns;
    start = 1'b1;
    exp_q.push_back(model(a, b, uns));
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    u     = $urandom_range(0, 1);
  endtask

  // Counts cycles from the accept edge to the cycle O_DONE is seen (-1 on timeout).
  task automatic wait_done(output int lat, output bit busy_bad);
    lat      = -1;
    busy_bad = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done && busy) busy_bad = 1'b1;
      if (n < 33 && !busy) busy_bad = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    u     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, quot, rem} !== 66'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h, want all 0",
               busy, done, quot, rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu_basic();
    int lat;
    bit bb;
    logic [63:0] exp;
    issue(32'd100, 32'd7, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL divu_busy_after_accept: got %b want 1", busy);
    end
    wait_done(lat, bb);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 33) begin
      n_fails++;
      $display("FAIL divu_latency: got %0d want 33", lat);
    end
    n_checks++;
    if (bb) begin
      n_fails++;
      $display("FAIL divu_busy_window: busy not high for 33 cycles or overlapped done");
    end
    n_checks++;
    if ({quot, rem} !== exp || exp !== {32'd14, 32'd2}) begin
      n_fails++;
      $display("FAIL divu_100_7: got q=%0d r=%0d want q=14 r=2", quot, rem);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL divu_done_pulse: got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic run_table(input string name, input logic [31:0] ta[], input logic [31:0] tb[],
                           input logic tu[], input logic [63:0] want[]);
    int lat;
    bit bb;
    logic [63:0] exp;
    for (int i = 0; i < ta.size(); i++) begin
      issue(ta[i], tb[i], tu[i]);
      wait_done(lat, bb);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 33 || bb) begin
        n_fails++;
        $display("FAIL %s_latency[%0d]: got %0d busy_bad=%b want 33", name, i, lat, bb);
      end
      n_checks++;
      if ({quot, rem} !== want[i] || exp !== want[i]) begin
        n_fails++;
        $display("FAIL %s_result[%0d]: got q=%h r=%h want q=%h r=%h",
                 name, i, quot, rem, want[i][63:32], want[i][31:0]);
      end
    end
  endtask

  task automatic test_signed();
    run_table("signed",
      '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9},
      '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE},
      '{1'b0, 1'b0, 1'b0},
      '{{32'hFFFF_FFFD, 32'hFFFF_FFFF}, {32'hFFFF_FFFD, 32'd1}, {32'd3, 32'hFFFF_FFFF}});
  endtask

  task automatic test_div0();
    run_table("div0",
      '{32'h1234_5678, 32'h1234_5678},
      '{32'd0, 32'd0},
      '{1'b0, 1'b1},
      '{{32'hFFFF_FFFF, 32'h1234_5678}, {32'hFFFF_FFFF, 32'h1234_5678}});
  endtask

  task automatic test_overflow();
    run_table("ovf",
      '{32'h8000_0000, 32'h8000_0000},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{1'b0, 1'b1},
      '{{32'h8000_0000, 32'd0}, {32'd0, 32'h8000_0000}});
  endtask

  task automatic test_random();
    int lat;
    bit bb;
    logic [63:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    logic uns;
    for (int i = 0; i < 40; i++) begin
      a   = rand_operand();
      b   = rand_operand();
      uns = $urandom_range(0, 1);
      issue(a, b, uns);
      wait_done(lat, bb);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 33 || bb || {quot, rem} !== exp) begin
        n_fails++;
        $display("FAIL random[%0d] a=%h b=%h u=%b: got q=%h r=%h lat=%0d want q=%h r=%h lat=33",
                 i, a, b, uns, quot, rem, lat, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    logic [63:0] exp;
    n = -1;
    issue(32'd1000, 32'd33, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        start = 1'b1;
        op_a  = 32'd77;
        op_b  = 32'd5;
        u     = 1'b1;
      end else if (c == 6) begin
        start = 1'b0;
      end
      if (done) begin
        n = c;
        break;
      end
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (n !== 33 || {quot, rem} !== exp) begin
      n_fails++;
      $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=33",
               quot, rem, n, exp[63:32], exp[31:0]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL ignore_start_no_restart: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n1;
    int n2;
    bit held_ok;
    logic [63:0] exp1;
    logic [63:0] exp2;
    n1 = -1;
    n2 = -1;
    held_ok = 1'b1;
    issue(32'hFFFF_FF00, 32'd3, 1'b0);
    exp1 = exp_q.pop_front();
    exp2 = model(32'd500, 32'hFFFF_FFF9, 1'b0);
    op_a  = 32'd500;
    op_b  = 32'hFFFF_FFF9;
    u     = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n1 = c;
        break;
      end
    end
    n_checks++;
    if (n1 !== 33 || {quot, rem} !== exp1) begin
      n_fails++;
      $display("FAIL b2b_first: got q=%h r=%h lat=%0d want q=%h r=%h lat=33",
               quot, rem, n1, exp1[63:32], exp1[31:0]);
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!done && {quot, rem} !== exp1) held_ok = 1'b0;
      if (done) begin
        n2 = c;
        break;
      end
    end
    n_checks++;
    if (n2 !== 34) begin
      n_fails++;
      $display("FAIL b2b_spacing: got %0d want 34", n2);
    end
    n_checks++;
    if (!held_ok) begin
      n_fails++;
      $display("FAIL b2b_hold: results changed before second done");
    end
    n_checks++;
    if ({quot, rem} !== exp2) begin
      n_fails++;
      $display("FAIL b2b_second: got q=%h r=%h want q=%h r=%h",
               quot, rem, exp2[63:32], exp2[31:0]);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit bb;
    bit saw_done;
    logic [63:0] exp;
    issue(32'd12345, 32'd11, 1'b1);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, quot, rem} !== 66'd0) begin
      n_fails++;
      $display("FAIL reset_mid_op: got busy=%b done=%b q=%h r=%h want all 0",
               busy, done, quot, rem);
    end
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fails++;
      $display("FAIL reset_abort: got done/busy after abort, want none");
    end
    issue(32'hFFFF_FFFF, 32'd16, 1'b1);
    wait_done(lat, bb);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 33 || {quot, rem} !== exp || exp !== {32'h0FFF_FFFF, 32'd15}) begin
      n_fails++;
      $display("FAIL after_reset_divu: got q=%h r=%h lat=%0d want q=0fffffff r=f lat=33",
               quot, rem, lat);
    end
  endtask

  // Flags any cycle where busy and done are high together.
  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      n_checks++;
      n_fails++;
      $display("FAIL busy_done_overlap: got busy=1 done=1 want never both");
    end
  end

  // ---------------- sequence / report ----------------
  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div0();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
